// File: rtl/snn_sram_arbiter.sv
// snn_sram_arbiter
// Shares one single-port SRAM (1-cycle read latency) between the Wishbone
// host path and the inference engine. The engine normally wins contention;
// a saturating wait counter forces a host grant after HOST_MAX_WAIT denied
// cycles. Host writes are held off while inference is running (lock_i).
module snn_sram_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              lock_i,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              eng_req_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  output logic              eng_gnt_o,
  output logic              eng_rvalid_o,
  output logic [DATA_W-1:0] eng_rdata_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i,
  output logic [3:0]        host_wait_o
);

  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  // Who owns the data coming out of the SRAM in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_ENG  = 2'd2
  } owner_t;

  owner_t     owner_reg, owner_next;
  logic [3:0] host_wait_reg, host_wait_next;
  logic       host_elig;
  logic       host_win;
  logic       eng_win;

  // Arbitration: engine priority unless the host has waited its full budget.
  // Grants are forced low while reset is asserted.
  always_comb begin
    host_elig = host_req_i && !(host_we_i && lock_i);
    host_win  = 1'b0;
    eng_win   = 1'b0;
    if (!wb_rst_i) begin
      if (host_elig && (!eng_req_i || host_wait_reg == MAX_WAIT)) begin
        host_win = 1'b1;
      end else if (eng_req_i) begin
        eng_win = 1'b1;
      end
    end
  end

  // Next wait count and next read-return owner.
  always_comb begin
    host_wait_next = host_wait_reg;
    owner_next     = OWN_NONE;
    if (!host_req_i || host_win) begin
      host_wait_next = 4'd0;
    end else if (host_elig) begin
      if (host_wait_reg != MAX_WAIT) begin
        host_wait_next = host_wait_reg + 4'd1;
      end
    end
    // A write locked out only by lock_i leaves the count untouched.
    if (host_win && !host_we_i) begin
      owner_next = OWN_HOST;
    end else if (eng_win) begin
      owner_next = OWN_ENG;
    end
  end

  // State registers; async reset discards any read still in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      owner_reg     <= OWN_NONE;
      host_wait_reg <= 4'd0;
    end else begin
      owner_reg     <= owner_next;
      host_wait_reg <= host_wait_next;
    end
  end

  // SRAM port mux: quiet (deselected, zero bus) on idle cycles.
  always_comb begin
    sram_csb_o  = 1'b1;
    sram_web_o  = 1'b1;
    sram_addr_o = '0;
    sram_din_o  = '0;
    if (host_win) begin
      sram_csb_o  = 1'b0;
      sram_web_o  = !host_we_i;
      sram_addr_o = host_addr_i;
      sram_din_o  = host_wdata_i;
    end else if (eng_win) begin
      sram_csb_o  = 1'b0;
      sram_addr_o = eng_addr_i;
    end
  end

  assign host_gnt_o    = host_win;
  assign eng_gnt_o     = eng_win;
  assign host_wait_o   = host_wait_reg;
  assign host_rvalid_o = (owner_reg == OWN_HOST);
  assign eng_rvalid_o  = (owner_reg == OWN_ENG);
  assign host_rdata_o  = host_rvalid_o ? sram_dout_i : '0;
  assign eng_rdata_o   = eng_rvalid_o ? sram_dout_i : '0;

endmodule

// File: tb/tb_snn_sram_arbiter.sv
// Testbench for snn_sram_arbiter: directed stimulus with a read-return
// scoreboard. Stimulus pushes expected {data, cycle} per granted read; a
// negedge monitor pops on every rvalid and compares.
module tb_snn_sram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              lock;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              eng_req;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_gnt, eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;
  logic              sram_csb, sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic [3:0]        host_wait;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t eng_q[$];
  exp_t host_q[$];

  snn_sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX_WAIT(4)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .lock_i       (lock),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_gnt_o   (host_gnt),
    .host_rvalid_o(host_rvalid),
    .host_rdata_o (host_rdata),
    .eng_req_i    (eng_req),
    .eng_addr_i   (eng_addr),
    .eng_gnt_o    (eng_gnt),
    .eng_rvalid_o (eng_rvalid),
    .eng_rdata_o  (eng_rdata),
    .sram_csb_o   (sram_csb),
    .sram_web_o   (sram_web),
    .sram_addr_o  (sram_addr),
    .sram_din_o   (sram_din),
    .sram_dout_i  (sram_dout),
    .host_wait_o  (host_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: 1-cycle registered read, write on !web.
  logic [DATA_W-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    sram_dout = '0;
  end
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the head of its owner's queue.
  exp_t me;
  always @(negedge clk) begin
    if (eng_rvalid) begin
      if (eng_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL eng_unexpected_rvalid: got rdata 0x%0h expected no rvalid (cycle %0d)", eng_rdata, cyc);
      end else begin
        me = eng_q.pop_front();
        check("eng_rdata", 32'(eng_rdata), 32'(me.data));
        check("eng_rvalid_cycle", cyc, me.cyc);
        $display("eng read return data=0x%0h cycle=%0d", eng_rdata, cyc);
      end
    end else begin
      check("eng_rdata_idle_zero", 32'(eng_rdata), 0);
    end
    if (host_rvalid) begin
      if (host_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL host_unexpected_rvalid: got rdata 0x%0h expected no rvalid (cycle %0d)", host_rdata, cyc);
      end else begin
        me = host_q.pop_front();
        check("host_rdata", 32'(host_rdata), 32'(me.data));
        check("host_rvalid_cycle", cyc, me.cyc);
        $display("host read return data=0x%0h cycle=%0d", host_rdata, cyc);
      end
    end else begin
      check("host_rdata_idle_zero", 32'(host_rdata), 0);
    end
  end

  task automatic push_eng(input logic [DATA_W-1:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1;
    eng_q.push_back(e);
  endtask

  task automatic push_host(input logic [DATA_W-1:0] d);
    exp_t e;
    e.data = d; e.cyc = cyc + 1;
    host_q.push_back(e);
  endtask

  // Uncontended host write, granted in the cycle it is requested.
  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    check("hw_gnt", 32'(host_gnt), 1);
    check("hw_web", 32'(sram_web), 0);
    $display("host write addr=0x%0h data=0x%0h gnt=%0b", a, d, host_gnt);
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lock = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    eng_req = 1'b1; eng_addr = 10'h005;

    // Reset state, with an engine request held to confirm grants are gated.
    repeat (2) @(negedge clk);
    check("rst_eng_gnt", 32'(eng_gnt), 0);
    check("rst_host_gnt", 32'(host_gnt), 0);
    check("rst_csb", 32'(sram_csb), 1);
    check("rst_web", 32'(sram_web), 1);
    check("rst_eng_rvalid", 32'(eng_rvalid), 0);
    check("rst_host_rvalid", 32'(host_rvalid), 0);
    check("rst_host_wait", 32'(host_wait), 0);
    $display("reset state csb=%0b web=%0b wait=%0d", sram_csb, sram_web, host_wait);
    eng_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Preload through the host path.
    host_write(10'h005, 8'h3C);
    host_write(10'h010, 8'h77);
    host_write(10'h001, 8'h11);
    host_write(10'h002, 8'h22);
    host_write(10'h003, 8'h33);

    // Engine-only read.
    eng_req = 1'b1; eng_addr = 10'h005;
    @(negedge clk);
    check("eo_eng_gnt", 32'(eng_gnt), 1);
    check("eo_host_gnt", 32'(host_gnt), 0);
    check("eo_csb", 32'(sram_csb), 0);
    check("eo_web", 32'(sram_web), 1);
    check("eo_addr", 32'(sram_addr), 32'h005);
    push_eng(8'h3C);
    $display("engine read addr=0x005 gnt=%0b", eng_gnt);
    tick();
    eng_req = 1'b0;
    tick();

    // Contention: engine continuous, host read waits 4 cycles then wins.
    eng_req = 1'b1; eng_addr = 10'h005;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ct_eng_gnt", 32'(eng_gnt), 1);
      check("ct_host_gnt", 32'(host_gnt), 0);
      check("ct_host_wait", 32'(host_wait), i);
      push_eng(8'h3C);
      $display("contention cycle %0d eng_gnt=%0b host_gnt=%0b wait=%0d", i, eng_gnt, host_gnt, host_wait);
      tick();
    end
    @(negedge clk);
    check("ct_wait_max", 32'(host_wait), 4);
    check("ct_host_win", 32'(host_gnt), 1);
    check("ct_eng_denied", 32'(eng_gnt), 0);
    check("ct_host_addr", 32'(sram_addr), 32'h010);
    push_host(8'h77);
    $display("contention cycle 4 eng_gnt=%0b host_gnt=%0b wait=%0d", eng_gnt, host_gnt, host_wait);
    tick();
    host_req = 1'b0; eng_req = 1'b0;
    @(negedge clk);
    check("ct_wait_cleared", 32'(host_wait), 0);
    tick();

    // Lock: host write held off, counter frozen at 0.
    lock = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h020; host_wdata = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lk_host_gnt", 32'(host_gnt), 0);
      check("lk_host_wait", 32'(host_wait), 0);
      check("lk_csb", 32'(sram_csb), 1);
      tick();
    end
    $display("lock held 10 cycles host_gnt=%0b wait=%0d", host_gnt, host_wait);
    lock = 1'b0;
    @(negedge clk);
    check("lk_release_gnt", 32'(host_gnt), 1);
    check("lk_release_web", 32'(sram_web), 0);
    $display("lock released host write gnt=%0b", host_gnt);
    tick();
    host_req = 1'b0; host_we = 1'b0;
    eng_req = 1'b1; eng_addr = 10'h020;
    @(negedge clk);
    check("lk_eng_gnt", 32'(eng_gnt), 1);
    push_eng(8'hA5);
    tick();
    eng_req = 1'b0;

    // Back-to-back alternating reads.
    eng_req = 1'b1; eng_addr = 10'h001;
    @(negedge clk);
    check("bb_eng1_gnt", 32'(eng_gnt), 1);
    push_eng(8'h11);
    tick();
    eng_req = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h002;
    @(negedge clk);
    check("bb_host_gnt", 32'(host_gnt), 1);
    check("bb_host_eng_idle", 32'(eng_gnt), 0);
    push_host(8'h22);
    tick();
    host_req = 1'b0;
    eng_req = 1'b1; eng_addr = 10'h003;
    @(negedge clk);
    check("bb_eng3_gnt", 32'(eng_gnt), 1);
    push_eng(8'h33);
    $display("back-to-back reads issued");
    tick();
    eng_req = 1'b0;
    tick();

    // Async reset right after an engine grant: no data must come back.
    eng_req = 1'b1; eng_addr = 10'h005;
    @(negedge clk);
    check("ar_eng_gnt", 32'(eng_gnt), 1);
    #1 rst = 1'b1;
    #1;
    check("ar_csb_immediate", 32'(sram_csb), 1);
    check("ar_gnt_low", 32'(eng_gnt), 0);
    eng_req = 1'b0;
    $display("async reset asserted csb=%0b gnt=%0b", sram_csb, eng_gnt);
    repeat (2) begin
      @(negedge clk);
      check("ar_eng_rvalid", 32'(eng_rvalid), 0);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("ar_post_rvalid", 32'(eng_rvalid), 0);
    tick();
    eng_req = 1'b1; eng_addr = 10'h003;
    @(negedge clk);
    check("ar_resume_gnt", 32'(eng_gnt), 1);
    push_eng(8'h33);
    $display("resume after reset engine read gnt=%0b", eng_gnt);
    tick();
    eng_req = 1'b0;

    repeat (3) tick();
    check("eng_q_drained", eng_q.size(), 0);
    check("host_q_drained", host_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
